// File: rtl/video_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : video_gen_pkg
//  Purpose  : Shared types, constants and the saturating score metric for the
//             clip scoring stage. The metric function is also used by the
//             bench's reference model.
//  Contents : chan_state_t  - per-channel FSM state
//             SCORE_W       - score width
//             *_BIAS_DEF    - default channel offsets
//             sat_score()   - clamped prompt + bias metric
//  Revision : 1.0 - initial release
// ============================================================================
package video_gen_pkg;

    typedef enum logic [0:0] {
        CH_EMPTY  = 1'b0,
        CH_LOADED = 1'b1
    } chan_state_t;

    localparam int SCORE_W = 8;

    localparam logic signed [8:0] MOTION_BIAS_DEF = 9'sd30;
    localparam logic signed [8:0] DETAIL_BIAS_DEF = -9'sd100;

    // Monotone slope-1 metric: prompt plus signed bias, clamped to [0, smax].
    // The sum is formed in 10 signed bits so that 255 + 255 and 0 - 256 both
    // fit without wrapping.
    function automatic logic [SCORE_W-1:0] sat_score(
        input logic [7:0]        prmt,
        input logic signed [8:0] bias,
        input logic [7:0]        smax = 8'd255
    );
        logic signed [9:0] sum;
        sum = $signed({2'b00, prmt}) + $signed({bias[8], bias});
        if (sum < 10'sd0) begin
            sat_score = '0;
        end else if (sum > $signed({2'b00, smax})) begin
            sat_score = smax;
        end else begin
            sat_score = sum[7:0];
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/clip_score_channel.sv
`default_nettype none
// ============================================================================
//  Module   : clip_score_channel
//  Purpose  : One scoring channel: latches a prompt on make, publishes the
//             clamped metric on check with one-cycle latency.
//  Ports    : clk, rst          - clock, async active-high reset
//             make, check, prmt - controller strobes and prompt
//             score             - last published score (registered)
//             valid             - one-cycle pulse after a publish
//             attempts          - saturating publish count
//             err_pulse         - combinational sequencing-error indication,
//                                 folded into a sticky flag by the parent
//  Revision : 1.0 - initial release
// ============================================================================
module clip_score_channel
    import video_gen_pkg::*;
#(
    parameter logic signed [8:0] BIAS      = 9'sd0,
    parameter logic [7:0]        SCORE_MAX = 8'd255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       make,
    input  logic       check,
    input  logic [7:0] prmt,
    output logic [7:0] score,
    output logic       valid,
    output logic [7:0] attempts,
    output logic       err_pulse
);

    chan_state_t r_state;
    logic [7:0]  r_prmt;
    logic [7:0]  r_score;
    logic        r_valid;
    logic [7:0]  r_attempts;

    // A check is an error when nothing is loaded, or when it collides with
    // a make (make wins, check is dropped).
    assign err_pulse = check & (make | (r_state == CH_EMPTY));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= CH_EMPTY;
            r_prmt     <= '0;
            r_score    <= '0;
            r_valid    <= 1'b0;
            r_attempts <= '0;
        end else begin
            r_valid <= 1'b0;
            if (make) begin
                r_prmt  <= prmt;
                r_state <= CH_LOADED;
            end else if (check && (r_state == CH_LOADED)) begin
                r_score <= sat_score(r_prmt, BIAS, SCORE_MAX);
                r_valid <= 1'b1;
                if (r_attempts != 8'hFF) begin
                    r_attempts <= r_attempts + 8'd1;
                end
                r_state <= CH_EMPTY;
            end
        end
    end

    assign score    = r_score;
    assign valid    = r_valid;
    assign attempts = r_attempts;

endmodule
`default_nettype wire

// File: rtl/clip_scorer.sv
`default_nettype none
// ============================================================================
//  Module   : clip_scorer
//  Purpose  : Motion and detail scoring stage downstream of the video
//             generation controller. Two independent channels plus a sticky
//             sequencing-error flag.
//  Ports    : clk, rst                             - clock, async reset
//             make_*/check_*/*_prmt                - per-channel controls
//             *_score, *_valid, *_attempts         - per-channel results
//             seq_err                              - sticky error, rst clears
//  Revision : 1.0 - initial release
// ============================================================================
module clip_scorer
    import video_gen_pkg::*;
#(
    parameter logic signed [8:0] MOTION_BIAS = MOTION_BIAS_DEF,
    parameter logic signed [8:0] DETAIL_BIAS = DETAIL_BIAS_DEF,
    parameter logic [7:0]        SCORE_MAX   = 8'd255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       make_motion,
    input  logic       check_motion,
    input  logic [7:0] motion_prmt,
    input  logic       make_detail,
    input  logic       check_detail,
    input  logic [7:0] detail_prmt,
    output logic [7:0] motion_score,
    output logic [7:0] detail_score,
    output logic       motion_valid,
    output logic       detail_valid,
    output logic [7:0] motion_attempts,
    output logic [7:0] detail_attempts,
    output logic       seq_err
);

    logic w_err_motion;
    logic w_err_detail;
    logic r_seq_err;

    clip_score_channel #(
        .BIAS      (MOTION_BIAS),
        .SCORE_MAX (SCORE_MAX)
    ) u_motion (
        .clk       (clk),
        .rst       (rst),
        .make      (make_motion),
        .check     (check_motion),
        .prmt      (motion_prmt),
        .score     (motion_score),
        .valid     (motion_valid),
        .attempts  (motion_attempts),
        .err_pulse (w_err_motion)
    );

    clip_score_channel #(
        .BIAS      (DETAIL_BIAS),
        .SCORE_MAX (SCORE_MAX)
    ) u_detail (
        .clk       (clk),
        .rst       (rst),
        .make      (make_detail),
        .check     (check_detail),
        .prmt      (detail_prmt),
        .score     (detail_score),
        .valid     (detail_valid),
        .attempts  (detail_attempts),
        .err_pulse (w_err_detail)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seq_err <= 1'b0;
        end else if (w_err_motion || w_err_detail) begin
            r_seq_err <= 1'b1;
        end
    end

    assign seq_err = r_seq_err;

endmodule
`default_nettype wire

// File: tb/tb_clip_scorer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_clip_scorer
//  Purpose  : Self-checking bench for clip_scorer: table of single-channel
//             publishes plus directed sequences for errors, relatch, async
//             reset and a closed-loop controller.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_clip_scorer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       make_motion = 1'b0, check_motion = 1'b0;
    logic       make_detail = 1'b0, check_detail = 1'b0;
    logic [7:0] motion_prmt = '0, detail_prmt = '0;
    logic [7:0] motion_score, detail_score;
    logic       motion_valid, detail_valid;
    logic [7:0] motion_attempts, detail_attempts;
    logic       seq_err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    clip_scorer dut (
        .clk             (clk),
        .rst             (rst),
        .make_motion     (make_motion),
        .check_motion    (check_motion),
        .motion_prmt     (motion_prmt),
        .make_detail     (make_detail),
        .check_detail    (check_detail),
        .detail_prmt     (detail_prmt),
        .motion_score    (motion_score),
        .detail_score    (detail_score),
        .motion_valid    (motion_valid),
        .detail_valid    (detail_valid),
        .motion_attempts (motion_attempts),
        .detail_attempts (detail_attempts),
        .seq_err         (seq_err)
    );

    typedef struct {
        logic       is_detail;
        logic [7:0] prmt;
        logic [7:0] exp_score;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    // make then check on one channel; leaves bench one cycle after the check.
    task automatic publish(input logic is_detail, input logic [7:0] p);
        if (is_detail) begin
            detail_prmt = p; make_detail = 1'b1;
            tick();
            make_detail = 1'b0; check_detail = 1'b1;
            tick();
            check_detail = 1'b0;
        end else begin
            motion_prmt = p; make_motion = 1'b1;
            tick();
            make_motion = 1'b0; check_motion = 1'b1;
            tick();
            check_motion = 1'b0;
        end
    endtask

    int         exp_m_att, exp_d_att;
    logic [7:0] saved_score, saved_att;
    logic [7:0] m_p, d_p;
    int         m_att, d_att;
    logic       m_done, d_done;

    initial begin
        vecs[0] = '{1'b0, 8'd50,  8'd80};
        vecs[1] = '{1'b0, 8'd250, 8'd255};
        vecs[2] = '{1'b0, 8'd0,   8'd30};
        vecs[3] = '{1'b0, 8'd225, 8'd255};
        vecs[4] = '{1'b0, 8'd224, 8'd254};
        vecs[5] = '{1'b1, 8'd150, 8'd50};
        vecs[6] = '{1'b1, 8'd60,  8'd0};
        vecs[7] = '{1'b1, 8'd100, 8'd0};
        vecs[8] = '{1'b1, 8'd101, 8'd1};
        vecs[9] = '{1'b1, 8'd255, 8'd155};

        do_reset();
        chk("reset motion_score", motion_score, 0);
        chk("reset detail_score", detail_score, 0);
        chk("reset valids", {motion_valid, detail_valid}, 0);
        chk("reset attempts", {motion_attempts, detail_attempts}, 0);
        chk("reset seq_err", seq_err, 0);

        // ---------------- table-driven publishes ----------------
        exp_m_att = 0; exp_d_att = 0;
        for (int i = 0; i < 10; i++) begin
            publish(vecs[i].is_detail, vecs[i].prmt);
            if (vecs[i].is_detail) begin
                exp_d_att++;
                chk($sformatf("vec%0d detail_score", i), detail_score, vecs[i].exp_score);
                chk($sformatf("vec%0d detail_valid", i), detail_valid, 1);
                chk($sformatf("vec%0d detail_attempts", i), detail_attempts, exp_d_att);
                chk($sformatf("vec%0d motion_valid quiet", i), motion_valid, 0);
            end else begin
                exp_m_att++;
                chk($sformatf("vec%0d motion_score", i), motion_score, vecs[i].exp_score);
                chk($sformatf("vec%0d motion_valid", i), motion_valid, 1);
                chk($sformatf("vec%0d motion_attempts", i), motion_attempts, exp_m_att);
                chk($sformatf("vec%0d detail_valid quiet", i), detail_valid, 0);
            end
            tick();
            chk($sformatf("vec%0d valid drop", i), {motion_valid, detail_valid}, 0);
            chk($sformatf("vec%0d score hold", i),
                vecs[i].is_detail ? detail_score : motion_score, vecs[i].exp_score);
        end
        chk("table seq_err", seq_err, 0);

        // ---------------- check with nothing loaded ----------------
        saved_score = detail_score;
        saved_att   = detail_attempts;
        check_detail = 1'b1;
        tick();
        check_detail = 1'b0;
        chk("empty check seq_err", seq_err, 1);
        chk("empty check detail_valid", detail_valid, 0);
        chk("empty check detail_score", detail_score, saved_score);
        chk("empty check detail_attempts", detail_attempts, saved_att);

        // ---------------- make+check collision ----------------
        do_reset();
        motion_prmt = 8'd20; make_motion = 1'b1; check_motion = 1'b1;
        tick();
        make_motion = 1'b0; check_motion = 1'b0;
        chk("collide seq_err", seq_err, 1);
        chk("collide motion_valid", motion_valid, 0);
        chk("collide motion_attempts", motion_attempts, 0);
        check_motion = 1'b1;
        tick();
        check_motion = 1'b0;
        chk("collide later publish score", motion_score, 50);
        chk("collide later publish valid", motion_valid, 1);
        chk("collide later publish attempts", motion_attempts, 1);

        // ---------------- relatch ----------------
        do_reset();
        motion_prmt = 8'd10; make_motion = 1'b1;
        tick();
        motion_prmt = 8'd40;
        tick();
        make_motion = 1'b0; check_motion = 1'b1;
        tick();
        check_motion = 1'b0;
        chk("relatch motion_score", motion_score, 70);
        chk("relatch seq_err", seq_err, 0);

        // ---------------- async reset mid-cycle ----------------
        do_reset();
        publish(1'b0, 8'd50);
        publish(1'b1, 8'd150);
        check_detail = 1'b1;     // set seq_err so reset has something to clear
        tick();
        check_detail = 1'b0;
        motion_prmt = 8'd77; make_motion = 1'b1;
        tick();
        make_motion = 1'b0;
        chk("pre-reset motion_score", motion_score, 80);
        chk("pre-reset seq_err", seq_err, 1);
        #2 rst = 1'b1;
        #1;
        chk("async rst motion_score", motion_score, 0);
        chk("async rst detail_score", detail_score, 0);
        chk("async rst attempts", {motion_attempts, detail_attempts}, 0);
        chk("async rst seq_err", seq_err, 0);
        tick();
        rst = 1'b0;
        tick();
        check_motion = 1'b1;
        tick();
        check_motion = 1'b0;
        chk("post-reset check seq_err", seq_err, 1);
        chk("post-reset check valid", motion_valid, 0);
        chk("post-reset check attempts", motion_attempts, 0);

        // ---------------- closed loop, both channels together ----------------
        do_reset();
        m_p = 8'd50; d_p = 8'd150; m_att = 0; d_att = 0;
        m_done = 1'b0; d_done = 1'b0;
        for (int it = 0; it < 64 && !(m_done && d_done); it++) begin
            motion_prmt = m_p; detail_prmt = d_p;
            make_motion = !m_done; make_detail = !d_done;
            tick();
            make_motion = 1'b0; make_detail = 1'b0;
            check_motion = !m_done; check_detail = !d_done;
            tick();
            check_motion = 1'b0; check_detail = 1'b0;
            if (!m_done) begin
                m_att++;
                if (motion_score == 8'd100) m_done = 1'b1;
                else if (motion_score < 8'd100) m_p = m_p + 8'd1;
                else m_p = m_p - 8'd1;
            end
            if (!d_done) begin
                d_att++;
                if (detail_score == 8'd30) d_done = 1'b1;
                else if (detail_score < 8'd30) d_p = d_p + 8'd1;
                else d_p = d_p - 8'd1;
            end
        end
        chk("loop motion converged", m_done, 1);
        chk("loop detail converged", d_done, 1);
        chk("loop motion prmt", m_p, 70);
        chk("loop detail prmt", d_p, 130);
        chk("loop motion model attempts", m_att, 21);
        chk("loop detail model attempts", d_att, 21);
        chk("loop motion_attempts", motion_attempts, 21);
        chk("loop detail_attempts", detail_attempts, 21);
        chk("loop seq_err", seq_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/clip_scorer.md
Name: clip_scorer

Overview:
- Scoring stage that sits directly downstream of the video-generation controller.
- Consumes the controller's make/check strobes and prompt parameters for the motion and detail channels.
- Returns the 8-bit motion_score and detail_score that the controller compares against its targets.
- Each channel latches a prompt on "make", evaluates a deterministic saturating metric, and publishes the score on "check" with one-cycle latency. The controller can therefore sample the score in the cycle after its check strobe.

Parameters:
- MOTION_BIAS, 30, signed 9-bit offset added to motion_prmt to form motion_score.
- DETAIL_BIAS, -100, signed 9-bit offset added to detail_prmt to form detail_score.
- SCORE_MAX, 255, upper clamp of any score; must be ≤255.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- make_motion  input  1  strobe: latch motion_prmt
- check_motion  input  1  strobe: publish motion score
- motion_prmt  input  8  motion prompt parameter, unsigned
- make_detail  input  1  strobe: latch detail_prmt
- check_detail  input  1  strobe: publish detail score
- detail_prmt  input  8  detail prompt parameter, unsigned
- motion_score  output  8  last published motion score
- detail_score  output  8  last published detail score
- motion_valid  output  1  high for 1 cycle after a motion publish
- detail_valid  output  1  high for 1 cycle after a detail publish
- motion_attempts  output  8  count of motion publishes, saturating at 255
- detail_attempts  output  8  count of detail publishes, saturating at 255
- seq_err  output  1  sticky sequencing-error flag

Behaviour:
- Reset (async, immediate): all outputs 0; both channel FSMs go to EMPTY; latched prompts 0. Reset mid-evaluation discards any latched prompt.
- Clock and reset are the only ones in the block; there is one clock domain.
- Per-channel FSM (identical for motion and detail):
  - EMPTY, make=1: latch prmt → LOADED.
  - EMPTY, check=1 (no make): seq_err <= 1; score unchanged; valid stays 0; attempts unchanged; stay EMPTY.
  - LOADED, make=1: relatch prmt (overwrite, no error); stay LOADED.
  - LOADED, check=1: score <= metric(latched prmt); valid <= 1 for exactly one cycle; attempts <= sat_inc(attempts) → EMPTY.
  - make=1 and check=1 in the same cycle, any state: make is taken (latch, → LOADED); check is ignored; seq_err <= 1.
- Metric:
  - sum = signed 10-bit {2'b00, prmt} + sign-extended BIAS.
  - score = 0 if sum < 0; SCORE_MAX if sum > SCORE_MAX; else sum[7:0].
  - The metric is monotone with slope 1, so a ±1 prompt step changes an unclamped score by exactly ±1. This guarantees the controller can hit any reachable target.
- Latency:
  - make at cycle t, check at cycle t+1 → score and valid visible from cycle t+2.
  - The score holds until the next publish on that channel.
- Channels are fully independent; simultaneous activity on both channels is legal.
- seq_err clears only on rst.
- attempts counters stick at 255 and do not wrap.
- No combinational path from inputs to outputs; all outputs are registered.

Decomposition:
- Package video_gen_pkg:
  - typedef enum chan_state_t {CH_EMPTY, CH_LOADED};
  - localparam SCORE_W = 8;
  - default bias constants MOTION_BIAS_DEF = 30, DETAIL_BIAS_DEF = -100;
  - function sat_score(prmt, bias) returning the clamped metric, shared with the bench reference model.
- Sub-module clip_score_channel:
  - parameter BIAS;
  - contains one FSM, prompt latch, score register, valid pulse, attempts counter, and an err_pulse output.
  - clip_scorer instantiates it twice and ORs the err_pulse outputs into the sticky seq_err.

Test Plan:
- Basic motion: motion_prmt=50, make_motion 1 cycle, then check_motion next cycle → from the following cycle motion_score=80, motion_valid high 1 cycle, motion_attempts=1.
- Clamping:
  - detail_prmt=150 → detail_score=50.
  - detail_prmt=60 → detail_score=0.
  - motion_prmt=250 → motion_score=255.
- Sequencing errors:
  - check_detail with no prior make → seq_err=1, detail_score unchanged, detail_valid=0, detail_attempts unchanged.
  - make+check in the same cycle → seq_err=1, channel LOADED; a subsequent check publishes normally.
- Relatch: make_motion with prmt=10, then make_motion with prmt=40, then check → motion_score=70 (not 40), seq_err stays 0.
- Async reset: assert rst mid-cycle while the motion channel is LOADED → all outputs 0 immediately, without waiting for a clock edge. A check after release → seq_err=1.
- Closed loop with a behavioural controller model (motion target 100 from prmt 50; detail target 30 from prmt 150 with aim=3'b001):
  - motion converges at prmt=70 after 21 attempts;
  - detail converges at prmt=130 after 21 attempts;
  - seq_err stays 0 throughout.
